// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage sequencer for RV32M DIV/DIVU/REM/REMU.
// Takes one request from EX and converts the operands to unsigned magnitudes.
// It handles divide-by-zero and signed overflow locally. All other requests are
// run on the external iterative divider through a level-held start and a ready
// handshake. The result gets its sign fixed up and is sent out as a single-cycle
// writeback.
module div_ctrl #(
    parameter int MIN_LAT = 2,   // ISSUE cycles during which div_ready_i is ignored
    parameter int TIMEOUT = 48   // ISSUE cycles before the operation is abandoned
) (
    input  logic        clk,
    input  logic        rst,            // synchronous, active low
    input  logic        req_valid_i,
    input  logic [1:0]  req_op_i,       // 00 DIV, 01 DIVU, 10 REM, 11 REMU
    input  logic [31:0] req_dividend_i,
    input  logic [31:0] req_divisor_i,
    input  logic [4:0]  req_rd_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        div_start_o,
    output logic [31:0] div_dividend_o,
    output logic [31:0] div_divisor_o,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,   // {remainder, quotient}
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        err_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_FIX   = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    // Registered state and the combinational next values
    state_t        r_state,    w_state_next;
    logic [1:0]    r_op,       w_op_next;
    logic [4:0]    r_rd,       w_rd_next;
    logic          r_neg_q,    w_neg_q_next;
    logic          r_neg_r,    w_neg_r_next;
    logic [31:0]   r_dividend, w_dividend_next;
    logic [31:0]   r_divisor,  w_divisor_next;
    logic [31:0]   r_val,      w_val_next;
    logic [CW-1:0] r_cnt,      w_cnt_next;
    logic          r_start,    w_start_next;
    logic          r_err,      w_err_next;
    logic [4:0]    r_wb_rd,    w_wb_rd_next;
    logic [31:0]   r_wb_data,  w_wb_data_next;

    // Request decode
    logic          w_req_signed;
    logic          w_req_rem;
    logic          w_a_neg;
    logic          w_b_neg;
    logic [31:0]   w_a_mag;
    logic [31:0]   w_b_mag;
    logic          w_div_zero;
    logic          w_ovf;
    logic [31:0]   w_special_data;
    logic          w_accept;

    // Issue / fix-up helpers
    logic          w_ready_ok;
    logic          w_timeout;
    logic [31:0]   w_sel_result;
    logic          w_fix_neg;
    logic [31:0]   w_fix_data;

    // Only the signed ops see negative operands; unsigned ops pass through untouched.
    assign w_req_signed = ~req_op_i[0];
    assign w_req_rem    = req_op_i[1];
    assign w_a_neg      = w_req_signed & req_dividend_i[31];
    assign w_b_neg      = w_req_signed & req_divisor_i[31];
    assign w_a_mag      = w_a_neg ? (~req_dividend_i + 32'd1) : req_dividend_i;
    assign w_b_mag      = w_b_neg ? (~req_divisor_i + 32'd1) : req_divisor_i;

    // Cases with an architecturally defined result that never reach the divider
    assign w_div_zero   = (req_divisor_i == 32'd0);
    assign w_ovf        = w_req_signed
                          & (req_dividend_i == 32'h8000_0000)
                          & (req_divisor_i  == 32'hFFFF_FFFF);
    assign w_special_data = w_div_zero ? (w_req_rem ? req_dividend_i : 32'hFFFF_FFFF)
                                       : (w_req_rem ? 32'h0000_0000  : 32'h8000_0000);

    assign w_accept     = (r_state == S_IDLE) & req_valid_i & ~flush_i;

    // The first MIN_LAT ISSUE cycles may see a ready still left over from an aborted op.
    assign w_ready_ok   = div_ready_i & (r_cnt >= CW'(MIN_LAT));
    assign w_timeout    = (r_cnt == CW'(TIMEOUT - 1));
    assign w_sel_result = r_op[1] ? div_result_i[63:32] : div_result_i[31:0];

    // neg_q/neg_r are already zero for unsigned ops, so the op only picks which flag applies.
    assign w_fix_neg    = r_op[1] ? r_neg_r : r_neg_q;
    assign w_fix_data   = w_fix_neg ? (~r_val + 32'd1) : r_val;

    // Next-state and datapath update logic for the sequencer
    always_comb begin
        w_state_next    = r_state;
        w_op_next       = r_op;
        w_rd_next       = r_rd;
        w_neg_q_next    = r_neg_q;
        w_neg_r_next    = r_neg_r;
        w_dividend_next = r_dividend;
        w_divisor_next  = r_divisor;
        w_val_next      = r_val;
        w_cnt_next      = r_cnt;
        w_start_next    = r_start;
        w_err_next      = 1'b0;
        w_wb_rd_next    = r_wb_rd;
        w_wb_data_next  = r_wb_data;

        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_op_next       = req_op_i;
                    w_rd_next       = req_rd_i;
                    w_neg_q_next    = w_a_neg ^ w_b_neg;
                    w_neg_r_next    = w_a_neg;
                    w_dividend_next = w_a_mag;
                    w_divisor_next  = w_b_mag;
                    if (w_div_zero | w_ovf) begin
                        // Result is already known, so write it back next cycle
                        w_wb_data_next = w_special_data;
                        w_wb_rd_next   = req_rd_i;
                        w_state_next   = S_OUT;
                    end else begin
                        w_start_next = 1'b1;
                        w_cnt_next   = '0;
                        w_state_next = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                w_cnt_next = r_cnt + 1'b1;
                if (flush_i) begin
                    w_start_next = 1'b0;
                    w_state_next = S_IDLE;
                end else if (w_ready_ok) begin
                    w_val_next   = w_sel_result;
                    w_start_next = 1'b0;
                    w_state_next = S_FIX;
                end else if (w_timeout) begin
                    w_start_next = 1'b0;
                    w_err_next   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end

            S_FIX: begin
                if (flush_i) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_wb_data_next = w_fix_data;
                    w_wb_rd_next   = r_rd;
                    w_state_next   = S_OUT;
                end
            end

            S_OUT: begin
                // Writeback cannot be cancelled once presented
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_op       <= 2'd0;
            r_rd       <= 5'd0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dividend <= 32'd0;
            r_divisor  <= 32'd0;
            r_val      <= 32'd0;
            r_cnt      <= '0;
            r_start    <= 1'b0;
            r_err      <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= 32'd0;
        end else begin
            r_state    <= w_state_next;
            r_op       <= w_op_next;
            r_rd       <= w_rd_next;
            r_neg_q    <= w_neg_q_next;
            r_neg_r    <= w_neg_r_next;
            r_dividend <= w_dividend_next;
            r_divisor  <= w_divisor_next;
            r_val      <= w_val_next;
            r_cnt      <= w_cnt_next;
            r_start    <= w_start_next;
            r_err      <= w_err_next;
            r_wb_rd    <= w_wb_rd_next;
            r_wb_data  <= w_wb_data_next;
        end
    end

    // busy_o drops in OUT so that EX advances together with the writeback
    assign busy_o         = w_accept | (r_state == S_ISSUE) | (r_state == S_FIX);
    assign div_start_o    = r_start;
    assign div_dividend_o = r_dividend;
    assign div_divisor_o  = r_divisor;
    assign wb_valid_o     = (r_state == S_OUT);
    assign wb_rd_o        = r_wb_rd;
    assign wb_data_o      = r_wb_data;
    assign err_o          = r_err;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: runs directed and random RV32M divide requests through div_ctrl.
// An external divider model sits next to the DUT. Each expected writeback is
// taken from plain signed/unsigned arithmetic and queued, and the monitor checks
// it against the writeback that the DUT produces.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic [1:0]  req_op_i;
    logic [31:0] req_dividend_i;
    logic [31:0] req_divisor_i;
    logic [4:0]  req_rd_i;
    logic        flush_i;
    logic        busy_o;
    logic        div_start_o;
    logic [31:0] div_dividend_o;
    logic [31:0] div_divisor_o;
    logic        div_ready_i;
    logic [63:0] div_result_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        err_o;

    always #5 clk = ~clk;

    div_ctrl #(.MIN_LAT(2), .TIMEOUT(48)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_op_i       (req_op_i),
        .req_dividend_i (req_dividend_i),
        .req_divisor_i  (req_divisor_i),
        .req_rd_i       (req_rd_i),
        .flush_i        (flush_i),
        .busy_o         (busy_o),
        .div_start_o    (div_start_o),
        .div_dividend_o (div_dividend_o),
        .div_divisor_o  (div_divisor_o),
        .div_ready_i    (div_ready_i),
        .div_result_i   (div_result_i),
        .wb_valid_o     (wb_valid_o),
        .wb_rd_o        (wb_rd_o),
        .wb_data_o      (wb_data_o),
        .err_o          (err_o)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t sb_q[$];
    int  checks   = 0;
    int  failures = 0;

    // Divider model controls
    int  m_lat    = 1;
    bit  m_stale  = 1'b0;
    bit  m_never  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // RISC-V M-extension result from the architectural rules
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            2'b00:   return 32'(sa / sb);
            2'b01:   return 32'(ua / ub);
            2'b10:   return 32'(sa % sb);
            default: return 32'(ua % ub);
        endcase
    endfunction

    function automatic logic [31:0] ref_mag(input logic [1:0] op, input logic [31:0] x);
        longint s;
        s = longint'($signed(x));
        if (!op[0] && s < 0) return 32'(-s);
        return x;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 20));
            5:       return 32'(-longint'($urandom_range(1, 20)));
            default: return $urandom;
        endcase
    endfunction

    // External iterative divider: ready after m_lat start cycles, held until start drops
    initial begin : divider_model
        int dcnt;
        dcnt         = 0;
        div_ready_i  = 1'b0;
        div_result_i = 64'd0;
        forever begin
            tick();
            if (!div_start_o) begin
                dcnt        = 0;
                div_ready_i = 1'b0;
            end else begin
                dcnt++;
                if (m_stale && dcnt == 1) begin
                    div_ready_i  = 1'b1;
                    div_result_i = {$urandom, $urandom};
                end else if (!m_never && dcnt >= m_lat) begin
                    div_ready_i = 1'b1;
                    if (div_divisor_o == 32'd0)
                        div_result_i = 64'hFFFF_FFFF_FFFF_FFFF;
                    else
                        div_result_i = {div_dividend_o % div_divisor_o, div_dividend_o / div_divisor_o};
                end else begin
                    div_ready_i = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: every writeback pops and compares one expected entry
    always @(negedge clk) begin : monitor
        wb_t e;
        if (wb_valid_o) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wb: got rd=%0d data=%08h expected no writeback", wb_rd_o, wb_data_o);
            end else begin
                e = sb_q.pop_front();
                $display("wb rd=%0d data=%08h (expect rd=%0d data=%08h)", wb_rd_o, wb_data_o, e.rd, e.data);
                check("wb_rd", 64'(wb_rd_o), 64'(e.rd));
                check("wb_data", 64'(wb_data_o), 64'(e.data));
            end
        end
    end

    // mode: 0 complete, 1 flush in 5th ISSUE cycle, 2 timeout, 3 reset mid-ISSUE, 4 flush during special OUT
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int lat, input bit stale, input int mode);
        bit          special;
        logic [31:0] exp;
        int          c;
        int          k;
        wb_t         ent;
        special = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        exp     = ref_result(op, a, b);
        m_lat   = lat;
        m_stale = stale;
        m_never = (mode == 2);

        req_valid_i    = 1'b1;
        req_op_i       = op;
        req_dividend_i = a;
        req_divisor_i  = b;
        req_rd_i       = rd;
        #1;
        check("busy_on_req", 64'(busy_o), 64'd1);
        if (mode == 0 || mode == 4) begin
            ent.rd   = rd;
            ent.data = exp;
            sb_q.push_back(ent);
        end
        tick();
        req_valid_i = 1'b0;
        c = 1;

        if (special) begin
            if (mode == 4) flush_i = 1'b1;
            check("special_wb_t1", 64'(wb_valid_o), 64'd1);
            check("special_no_start", 64'(div_start_o), 64'd0);
            check("special_busy_low", 64'(busy_o), 64'd0);
            tick();
            flush_i = 1'b0;
            check("special_one_cycle", 64'(wb_valid_o), 64'd0);
            check("special_start_low", 64'(div_start_o), 64'd0);
            check("special_hold_data", 64'(wb_data_o), 64'(exp));
            return;
        end

        check("start_t1", 64'(div_start_o), 64'd1);
        check("dividend_mag", 64'(div_dividend_o), 64'(ref_mag(op, a)));
        check("divisor_mag", 64'(div_divisor_o), 64'(ref_mag(op, b)));

        case (mode)
            1: begin
                repeat (4) tick();
                flush_i = 1'b1;
                check("flush_busy_issue", 64'(busy_o), 64'd1);
                tick();
                flush_i = 1'b0;
                check("flush_start_low", 64'(div_start_o), 64'd0);
                check("flush_busy_low", 64'(busy_o), 64'd0);
                check("flush_no_wb", 64'(wb_valid_o), 64'd0);
                $display("op flushed rd=%0d", rd);
            end
            2: begin
                repeat (47) tick();
                check("timeout_busy_last", 64'(busy_o), 64'd1);
                check("timeout_err_early", 64'(err_o), 64'd0);
                tick();
                check("timeout_err", 64'(err_o), 64'd1);
                check("timeout_busy_low", 64'(busy_o), 64'd0);
                check("timeout_start_low", 64'(div_start_o), 64'd0);
                check("timeout_no_wb", 64'(wb_valid_o), 64'd0);
                tick();
                check("timeout_err_pulse", 64'(err_o), 64'd0);
                $display("op timed out rd=%0d", rd);
            end
            3: begin
                repeat (2) tick();
                rst = 1'b0;
                tick();
                check("rst_start", 64'(div_start_o), 64'd0);
                check("rst_busy", 64'(busy_o), 64'd0);
                check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
                check("rst_err", 64'(err_o), 64'd0);
                check("rst_wb_data", 64'(wb_data_o), 64'd0);
                check("rst_wb_rd", 64'(wb_rd_o), 64'd0);
                check("rst_div_dividend", 64'(div_dividend_o), 64'd0);
                rst = 1'b1;
                tick();
                $display("op reset rd=%0d", rd);
            end
            default: begin
                k = (lat - 1 > 2) ? lat - 1 : 2;
                while (!wb_valid_o && c < 80) begin
                    tick();
                    c++;
                end
                check("wb_latency", 64'(c), 64'(3 + k));
                check("out_busy_low", 64'(busy_o), 64'd0);
                check("out_start_low", 64'(div_start_o), 64'd0);
                tick();
                check("wb_one_cycle", 64'(wb_valid_o), 64'd0);
                check("hold_data", 64'(wb_data_o), 64'(exp));
                check("hold_rd", 64'(wb_rd_o), 64'(rd));
                check("no_err", 64'(err_o), 64'd0);
            end
        endcase
    endtask

    // Main stimulus
    initial begin : driver
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        bit          stale;

        rst            = 1'b0;
        req_valid_i    = 1'b0;
        req_op_i       = 2'd0;
        req_dividend_i = 32'd0;
        req_divisor_i  = 32'd0;
        req_rd_i       = 5'd0;
        flush_i        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_start", 64'(div_start_o), 64'd0);
        check("reset_wb_valid", 64'(wb_valid_o), 64'd0);
        check("reset_wb_data", 64'(wb_data_o), 64'd0);
        check("reset_wb_rd", 64'(wb_rd_o), 64'd0);
        check("reset_err", 64'(err_o), 64'd0);
        check("reset_div_divisor", 64'(div_divisor_o), 64'd0);
        rst = 1'b1;
        tick();

        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, 3, 1'b0, 0);   // DIV -7/2 = -3
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2, 1, 1'b0, 0);   // REM -7/2 = -1
        run_op(2'b01, 32'hFFFF_FFFE, 32'd2, 5'd3, 4, 1'b0, 0);   // DIVU
        run_op(2'b11, 32'd7, 32'd0, 5'd4, 1, 1'b0, 0);           // REMU by zero
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 1, 1'b0, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1, 1'b0, 0);
        run_op(2'b01, 32'd12345, 32'd77, 5'd7, 30, 1'b0, 1);     // flushed
        run_op(2'b01, 32'd10, 32'd3, 5'd8, 2, 1'b0, 0);          // DIVU 10/3
        run_op(2'b00, 32'd100, 32'hFFFF_FFF7, 5'd9, 6, 1'b1, 0); // stale ready ignored
        run_op(2'b11, 32'd1000, 32'd7, 5'd10, 1, 1'b0, 2);       // timeout
        run_op(2'b00, 32'hFFFF_FFCE, 32'd3, 5'd11, 1, 1'b0, 0);
        run_op(2'b10, 32'd99, 32'd5, 5'd12, 20, 1'b0, 3);        // reset mid-ISSUE
        run_op(2'b10, 32'd99, 32'd5, 5'd13, 5, 1'b0, 0);
        run_op(2'b00, 32'd5, 32'd0, 5'd14, 1, 1'b0, 4);          // flush ignored in OUT

        for (int i = 0; i < 150; i++) begin
            op    = 2'($urandom_range(0, 3));
            a     = pick_operand();
            b     = pick_operand();
            lat   = $urandom_range(1, 20);
            stale = ($urandom_range(0, 5) == 0);
            if (stale && lat < 5) lat = lat + 5;
            run_op(op, a, b, 5'($urandom_range(1, 31)), lat, stale, 0);
        end

        tick();
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
